router_reg: RTL and testbench
=============================

// Module: router_reg
// PURPOSE
//  Datapath register stage of the 1x3 router, directly downstream of router_fsm.
//  Consumes the FSM state strobes and sequences header, payload and parity bytes onto dout for the FIFO write path.
//  Holds a byte stalled by a full FIFO and computes running XOR parity.
//  Returns parity_done and low_pkt_valid to the FSM and raises err on a parity mismatch.
// PARAMETERS
//  DATA_W   8   byte width of data_in/dout
//  ADDR_W   2   header destination field width, header[ADDR_W-1:0]; addr 2'b11 is invalid
// PORTS
//  clk            in   1       system clock, rising edge
//  rstn           in   1       reset, asynchronous, active-low
//  pkt_valid      in   1       source byte valid; deasserts with the parity byte
//  data_in        in   DATA_W  source byte
//  fifo_full      in   1       selected destination FIFO full
//  detect_addr    in   1       FSM DECODE_ADDRESS strobe
//  lfd_state      in   1       FSM LOAD_FIRST_DATA strobe
//  ld_state       in   1       FSM LOAD_DATA strobe
//  laf_state      in   1       FSM LOAD_AFTER_FULL strobe
//  full_state     in   1       FSM FIFO_FULL_STATE strobe
//  rst_int_reg    in   1       FSM CHECK_PARITY_ERROR strobe; clears low_pkt_valid
//  parity_done    out  1       parity byte captured; packet complete
//  low_pkt_valid  out  1       pkt_valid fell while in LOAD_DATA
//  err            out  1       received parity != computed parity
//  dout           out  DATA_W  byte to destination FIFO
// BEHAVIOUR
//  Reset: all outputs and all internal registers are 0 (hdr, hold, int_par, pkt_par, len_cnt).
//  Strobes are one-hot. All updates are registered, 1-cycle latency from the strobe edge.
//  hdr <= data_in when detect_addr & pkt_valid & data_in[ADDR_W-1:0] != all-ones.
//  dout, by priority:
//   - lfd_state: dout <= hdr.
//   - ld_state & !fifo_full: dout <= data_in.
//   - ld_state & fifo_full: hold <= data_in; dout unchanged.
//   - laf_state: dout <= hold.
//   - otherwise dout holds.
//  int_par:
//   - cleared on detect_addr.
//   - ^= hdr on lfd_state.
//   - ^= data_in on ld_state & pkt_valid & !full_state, including a byte diverted to hold.
//  pkt_par <= data_in on ld_state & !pkt_valid (parity byte).
//  low_pkt_valid:
//   - set on ld_state & !pkt_valid.
//   - cleared on rst_int_reg; clear wins over set.
//  parity_done:
//   - cleared on detect_addr.
//   - set on (ld_state & !fifo_full & !pkt_valid) | (laf_state & low_pkt_valid & !parity_done).
//   - sticky until the next detect_addr.
//  err:
//   - while parity_done=1, err <= (int_par != pkt_par); valid the cycle after parity_done rises.
//   - cleared on detect_addr.
//  Boundaries:
//   - Parity byte arriving with fifo_full=1: byte goes to hold; parity_done is set in laf_state, not ld_state.
//   - Invalid address 2'b11: hdr not updated; the previous header is retained but unused.
//   - full_state: dout, int_par and hold are all frozen.
//   - rstn low mid-packet: immediate clear of every register; no partial state survives.
// CONFIGURATION
//  ROUTER_REG_LEN_CHK_EN defined:
//   - len_cnt counts payload bytes folded into int_par; cleared on detect_addr.
//   - On parity_done, err <= parity mismatch | (len_cnt != hdr[DATA_W-1:ADDR_W]).
//   - len_cnt saturates at all-ones.
//  Undefined: no len_cnt logic; err reflects parity only.
// TESTING
//  T1 hdr 8'h0D, payload 11/22/33, parity 8'h0D, fifo_full=0 -> dout 0D,11,22,33; parity_done=1; err=0.
//  T2 same packet, parity 8'h0E -> err=1 one cycle after parity_done; cleared by next detect_addr.
//  T3 fifo_full=1 on payload 22 -> hold=22, dout stays 11 through full_state; laf_state -> dout=22; err=0.
//  T4 fifo_full=1 on parity byte -> parity_done is 0 in ld_state; set in laf_state with low_pkt_valid=1; rst_int_reg -> low_pkt_valid=0.
//  T5 hdr 8'h0F (addr 11) at detect_addr -> hdr unchanged; rstn pulse mid-payload -> all outputs 0 asynchronously.
//  T6 LEN_CHK_EN: hdr 8'h0D with 2 payload bytes and correct parity -> err=1; 3 bytes -> err=0.

Source files
------------

// File: rtl/router_reg.sv
`default_nettype none
// ============================================================================
// Module      : router_reg
// Description : Datapath register stage of the 1x3 router. Sequences the
//               header, payload and parity bytes onto dout under control of
//               the router_fsm state strobes. A byte that meets a full FIFO
//               is parked in a hold register. A running XOR parity is kept
//               and compared against the received parity byte.
// Options     : ROUTER_REG_LEN_CHK_EN - also flag an error when the payload
//               byte count differs from the header length field.
// Revision    : 1.0 - initial release
// ============================================================================
module router_reg #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              detect_addr,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    input  logic              rst_int_reg,
    output logic              parity_done,
    output logic              low_pkt_valid,
    output logic              err,
    output logic [DATA_W-1:0] dout
);

    localparam int                LEN_W          = DATA_W - ADDR_W;
    localparam logic [ADDR_W-1:0] C_ADDR_INVALID = {ADDR_W{1'b1}};

    logic [DATA_W-1:0] r_hdr;
    logic [DATA_W-1:0] r_hold;
    logic [DATA_W-1:0] r_dout;
    logic [DATA_W-1:0] r_int_par;
    logic [DATA_W-1:0] r_pkt_par;
    logic              r_low_pkt_valid;
    logic              r_parity_done;
    logic              r_err;

    logic w_hdr_load;
    logic w_par_fold;
    logic w_par_byte;
    logic w_done_set;
    logic w_par_mismatch;
    logic w_len_err;

    // Only a header with a routable address replaces the stored header.
    assign w_hdr_load     = detect_addr & pkt_valid & (data_in[ADDR_W-1:0] != C_ADDR_INVALID);
    // Every payload byte is folded in, including one diverted to hold.
    assign w_par_fold     = ld_state & pkt_valid & ~full_state;
    // pkt_valid low during LOAD_DATA marks the parity byte.
    assign w_par_byte     = ld_state & ~pkt_valid;
    // Parity byte written straight through, or flushed from hold after a stall.
    assign w_done_set     = (ld_state & ~fifo_full & ~pkt_valid)
                          | (laf_state & r_low_pkt_valid & ~r_parity_done);
    assign w_par_mismatch = (r_int_par != r_pkt_par);

`ifdef ROUTER_REG_LEN_CHK_EN
    localparam logic [LEN_W-1:0] C_LEN_MAX = {LEN_W{1'b1}};

    logic [LEN_W-1:0] r_len_cnt;

    // Count folded payload bytes, saturating so long packets cannot wrap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_len_cnt <= '0;
        end else if (detect_addr) begin
            r_len_cnt <= '0;
        end else if (w_par_fold && (r_len_cnt != C_LEN_MAX)) begin
            r_len_cnt <= r_len_cnt + 1'b1;
        end
    end

    assign w_len_err = (r_len_cnt != r_hdr[DATA_W-1:ADDR_W]);
`else
    assign w_len_err = 1'b0;
`endif

    // Header capture at address decode.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hdr <= '0;
        end else if (w_hdr_load) begin
            r_hdr <= data_in;
        end
    end

    // Output byte sequencing; a byte blocked by a full FIFO goes to hold.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dout <= '0;
            r_hold <= '0;
        end else if (lfd_state) begin
            r_dout <= r_hdr;
        end else if (ld_state && !fifo_full) begin
            r_dout <= data_in;
        end else if (ld_state && fifo_full) begin
            r_hold <= data_in;
        end else if (laf_state) begin
            r_dout <= r_hold;
        end
    end

    // Running parity over header and payload; received parity byte capture.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_int_par <= '0;
            r_pkt_par <= '0;
        end else begin
            if (detect_addr) begin
                r_int_par <= '0;
            end else if (lfd_state) begin
                r_int_par <= r_int_par ^ r_hdr;
            end else if (w_par_fold) begin
                r_int_par <= r_int_par ^ data_in;
            end
            if (w_par_byte) begin
                r_pkt_par <= data_in;
            end
        end
    end

    // End-of-packet flag to the FSM; the FSM clear takes precedence.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_low_pkt_valid <= 1'b0;
        end else if (rst_int_reg) begin
            r_low_pkt_valid <= 1'b0;
        end else if (w_par_byte) begin
            r_low_pkt_valid <= 1'b1;
        end
    end

    // Packet-complete flag, sticky until the next header.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_parity_done <= 1'b0;
        end else if (detect_addr) begin
            r_parity_done <= 1'b0;
        end else if (w_done_set) begin
            r_parity_done <= 1'b1;
        end
    end

    // Error evaluated once the parity byte is in, one cycle after parity_done.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err <= 1'b0;
        end else if (detect_addr) begin
            r_err <= 1'b0;
        end else if (r_parity_done) begin
            r_err <= w_par_mismatch | w_len_err;
        end
    end

    assign dout          = r_dout;
    assign parity_done   = r_parity_done;
    assign low_pkt_valid = r_low_pkt_valid;
    assign err           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_router_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_reg
// Description : Self-checking bench for router_reg. Packets are described at
//               transaction level (header, payload list, parity offset, stall
//               mask); expected bytes, parity and error follow from XOR sums.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_reg;

    logic       clk;
    logic       rstn;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       fifo_full;
    logic       detect_addr;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       rst_int_reg;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       err;
    logic [7:0] dout;

    int checks;
    int failures;

    // Header the design is expected to hold (only routable headers update it).
    logic [7:0] model_hdr;

    router_reg #(.DATA_W(8), .ADDR_W(2)) u_dut (
        .clk          (clk),
        .rstn         (rstn),
        .pkt_valid    (pkt_valid),
        .data_in      (data_in),
        .fifo_full    (fifo_full),
        .detect_addr  (detect_addr),
        .lfd_state    (lfd_state),
        .ld_state     (ld_state),
        .laf_state    (laf_state),
        .full_state   (full_state),
        .rst_int_reg  (rst_int_reg),
        .parity_done  (parity_done),
        .low_pkt_valid(low_pkt_valid),
        .err          (err),
        .dout         (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        pkt_valid   = 1'b0;
        data_in     = 8'h00;
        fifo_full   = 1'b0;
        detect_addr = 1'b0;
        lfd_state   = 1'b0;
        ld_state    = 1'b0;
        laf_state   = 1'b0;
        full_state  = 1'b0;
        rst_int_reg = 1'b0;
    endtask

    // Drive one full packet through the FSM strobe sequence and check it.
    // Parity byte sent = correct parity ^ par_xor; stall_mask bit i stalls byte i
    // (index n is the parity byte).
    task automatic send_packet(input logic [7:0] h, input logic [7:0] pl [16], input int n,
                               input logic [7:0] par_xor, input logic [15:0] stall_mask,
                               input string tag);
        logic [7:0]  bytes [17];
        logic [7:0]  calc;
        logic [7:0]  exp_dout;
        logic        exp_err;
        logic [10:0] got;
        logic [10:0] expv;
        logic        last;
        logic        stall;
        int          waits;

        detect_addr = 1'b1; pkt_valid = 1'b1; data_in = h; fifo_full = 1'b0;
        cyc();
        detect_addr = 1'b0;
        if (h[1:0] != 2'b11) model_hdr = h;
        checks++;
        if ({parity_done, err} !== 2'b00) begin
            failures++;
            $display("FAIL %s detect clears pd/err: got=%b exp=00", tag, {parity_done, err});
        end

        lfd_state = 1'b1; data_in = 8'($urandom);
        cyc();
        lfd_state = 1'b0;
        exp_dout = model_hdr;
        checks++;
        if (dout !== exp_dout) begin
            failures++;
            $display("FAIL %s lfd dout: got=%02h exp=%02h", tag, dout, exp_dout);
        end

        calc = model_hdr;
        for (int i = 0; i < n; i++) begin
            calc     = calc ^ pl[i];
            bytes[i] = pl[i];
        end
        bytes[n] = calc ^ par_xor;
        exp_err  = (par_xor != 8'h00);
`ifdef ROUTER_REG_LEN_CHK_EN
        exp_err  = exp_err | (((n > 63) ? 63 : n) != int'(model_hdr[7:2]));
`endif

        for (int i = 0; i <= n; i++) begin
            last  = (i == n);
            stall = stall_mask[i];
            ld_state = 1'b1; pkt_valid = !last; data_in = bytes[i]; fifo_full = stall;
            cyc();
            ld_state = 1'b0; fifo_full = 1'b0;
            if (!stall) exp_dout = bytes[i];
            got  = {dout, parity_done, low_pkt_valid, err};
            expv = {exp_dout, last & ~stall, last, 1'b0};
            checks++;
            if (got !== expv) begin
                failures++;
                $display("FAIL %s ld byte %0d {dout,pd,low,err}: got=%03h exp=%03h", tag, i, got, expv);
            end
            if (stall) begin
                waits = 1 + $urandom_range(0, 2);
                for (int w = 0; w < waits; w++) begin
                    full_state = 1'b1; fifo_full = 1'b1;
                    pkt_valid = 1'($urandom); data_in = 8'($urandom);
                    cyc();
                end
                full_state = 1'b0; fifo_full = 1'b0;
                expv = {exp_dout, 1'b0, last, 1'b0};
                got  = {dout, parity_done, low_pkt_valid, err};
                checks++;
                if (got !== expv) begin
                    failures++;
                    $display("FAIL %s full_state freeze byte %0d: got=%03h exp=%03h", tag, i, got, expv);
                end
                laf_state = 1'b1; data_in = 8'($urandom);
                cyc();
                laf_state = 1'b0;
                exp_dout = bytes[i];
                got  = {dout, parity_done, low_pkt_valid, err};
                expv = {exp_dout, last, last, 1'b0};
                checks++;
                if (got !== expv) begin
                    failures++;
                    $display("FAIL %s laf byte %0d: got=%03h exp=%03h", tag, i, got, expv);
                end
            end
        end

        pkt_valid = 1'b0; data_in = 8'h00;
        cyc();
        checks++;
        if ({parity_done, err} !== {1'b1, exp_err}) begin
            failures++;
            $display("FAIL %s err after pd: got pd/err=%b exp=%b", tag, {parity_done, err}, {1'b1, exp_err});
        end

        rst_int_reg = 1'b1;
        cyc();
        rst_int_reg = 1'b0;
        checks++;
        if ({parity_done, low_pkt_valid, err} !== {1'b1, 1'b0, exp_err}) begin
            failures++;
            $display("FAIL %s rst_int_reg pd/low/err: got=%b exp=%b", tag,
                     {parity_done, low_pkt_valid, err}, {1'b1, 1'b0, exp_err});
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rstn = 1'b0;
        cyc(); cyc();
        rstn = 1'b1;
        model_hdr = 8'h00;
        checks++;
        if ({parity_done, low_pkt_valid, err, dout} !== 11'h000) begin
            failures++;
            $display("FAIL reset outputs: got=%03h exp=000", {parity_done, low_pkt_valid, err, dout});
        end
        // laf right after reset: hold is zero and no parity_done without low_pkt_valid.
        laf_state = 1'b1;
        cyc();
        laf_state = 1'b0;
        checks++;
        if ({parity_done, dout} !== 9'h000) begin
            failures++;
            $display("FAIL reset hold/pd: got=%03h exp=000", {parity_done, dout});
        end
        lfd_state = 1'b1; data_in = 8'hFF;
        cyc();
        lfd_state = 1'b0;
        checks++;
        if (dout !== 8'h00) begin
            failures++;
            $display("FAIL reset hdr: got=%02h exp=00", dout);
        end
    endtask

    task automatic test_directed();
        logic [7:0] pl [16];
        foreach (pl[i]) pl[i] = 8'h00;
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        send_packet(8'h0D, pl, 3, 8'h00, 16'h0000, "T1_basic");
        send_packet(8'h0D, pl, 3, 8'h03, 16'h0000, "T2_bad_parity");
        send_packet(8'h0D, pl, 3, 8'h00, 16'h0002, "T3_payload_stall");
        send_packet(8'h0D, pl, 3, 8'h00, 16'h0008, "T4_parity_stall");
        send_packet(8'h0D, pl, 2, 8'h00, 16'h0000, "T6_short");
        send_packet(8'h0D, pl, 3, 8'h00, 16'h0000, "T6_exact");
    endtask

    task automatic test_invalid_addr_reset();
        logic [7:0] pl [16];
        foreach (pl[i]) pl[i] = 8'($urandom);
        send_packet(8'h12, pl, 4, 8'h00, 16'h0000, "T5_valid");
        send_packet(8'h0F, pl, 3, 8'h00, 16'h0000, "T5_invalid_addr");
        send_packet(8'h26, pl, 2, 8'h5A, 16'h0000, "T5_err_before_rst");

        // Async reset with pd/err set: clears without a clock edge.
        #1 rstn = 1'b0;
        #1;
        checks++;
        if ({parity_done, low_pkt_valid, err, dout} !== 11'h000) begin
            failures++;
            $display("FAIL async reset after pkt: got=%03h exp=000", {parity_done, low_pkt_valid, err, dout});
        end
        cyc();
        rstn = 1'b1;
        model_hdr = 8'h00;

        // Async reset mid-payload.
        detect_addr = 1'b1; pkt_valid = 1'b1; data_in = 8'h25;
        cyc();
        detect_addr = 1'b0; lfd_state = 1'b1;
        cyc();
        lfd_state = 1'b0; ld_state = 1'b1; data_in = 8'h5A;
        cyc();
        data_in = 8'hA5;
        cyc();
        ld_state = 1'b0;
        checks++;
        if (dout !== 8'hA5) begin
            failures++;
            $display("FAIL mid-payload dout before reset: got=%02h exp=a5", dout);
        end
        #1 rstn = 1'b0;
        #1;
        checks++;
        if ({parity_done, low_pkt_valid, err, dout} !== 11'h000) begin
            failures++;
            $display("FAIL async reset mid-payload: got=%03h exp=000", {parity_done, low_pkt_valid, err, dout});
        end
        clear_inputs();
        cyc();
        rstn = 1'b1;
        model_hdr = 8'h00;
        // Header register must also have been cleared: invalid address exposes it.
        send_packet(8'hFF, pl, 2, 8'h00, 16'h0000, "T5_hdr_cleared");
    endtask

    task automatic test_random();
        logic [7:0]  pl [16];
        logic [7:0]  h;
        logic [5:0]  lenf;
        logic [7:0]  px;
        logic [15:0] mask;
        int          n;
        for (int k = 0; k < 40; k++) begin
            n = 1 + $urandom_range(0, 7);
            foreach (pl[i]) pl[i] = 8'($urandom);
            lenf = ($urandom_range(0, 1) == 1) ? 6'(n) : 6'($urandom);
            h    = {lenf, 2'($urandom)};
            px   = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(1, 255));
            mask = 16'($urandom) & 16'($urandom);
            send_packet(h, pl, n, px, mask, "random");
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        model_hdr = 8'h00;
        rstn      = 1'b0;
        clear_inputs();
        test_reset();
        test_directed();
        test_invalid_addr_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
